alu_req_arbiter: RTL and testbench
==================================

// Module: alu_req_arbiter
// PURPOSE
//  Shares one combinational arithmetic unit `device` (in1/in2/opcode -> out) among
//  NUM_REQ requesters. Requesters hand over operands on a valid/ready handshake.
//  Round-robin arbitration selects one requester, issues its operation, and returns
//  the registered result with the requester ID on a valid/ready response channel.
//  Lives in the same top level as `device` and drives its inputs exclusively.
// PARAMETERS
//  NUM_REQ  2   number of requesters (2..8); ID width IDW = $clog2(NUM_REQ), min 1
//  DATA_W   4   operand width; result width is 2*DATA_W
//  CNT_W    16  width of completed-operation counter
// PORTS
//  clk        in   1                 rising-edge clock
//  rst        in   1                 synchronous, active-high reset
//  req_valid  in   NUM_REQ           per-requester request valid
//  req_ready  out  NUM_REQ           per-requester accept (one-hot or zero)
//  req_in1    in   NUM_REQ*DATA_W    operand A; requester i at [i*DATA_W +: DATA_W]
//  req_in2    in   NUM_REQ*DATA_W    operand B; same packing
//  req_opcode in   NUM_REQ*2         opcode; requester i at [i*2 +: 2]; 10=mul, 11=div
//  dev_in1    out  DATA_W            to device.in1
//  dev_in2    out  DATA_W            to device.in2
//  dev_opcode out  2                 to device.opcode
//  dev_out    in   2*DATA_W          from device.out
//  rsp_valid  out  1                 response valid
//  rsp_ready  in   1                 response accept
//  rsp_data   out  2*DATA_W          result
//  rsp_id     out  IDW               index of requester that owns rsp_data
//  rsp_err    out  1                 1 = divide by zero (opcode 11, in2 == 0)
//  busy       out  1                 1 whenever state != IDLE
//  op_count   out  CNT_W             completed responses, wraps to 0 past all-ones
// BEHAVIOUR
//  FSM: IDLE -> ISSUE -> RESP -> IDLE. Reset: state=IDLE, rr_ptr=0, op_count=0,
//   rsp_valid=0, rsp_data=0, rsp_id=0, rsp_err=0, operand regs=0, busy=0.
//  IDLE: if any req_valid, grant = first set bit searching rr_ptr, rr_ptr+1, ...
//   (mod NUM_REQ). req_ready[grant]=1 in that same cycle (combinational from
//   req_valid and rr_ptr); capture in1/in2/opcode/grant into regs; -> ISSUE.
//   No req_valid: stay IDLE, req_ready=0.
//  req_ready is 0 in ISSUE and RESP; at most one bit set in any cycle.
//  dev_in1/dev_in2/dev_opcode always equal the operand regs (0/0/00 after reset).
//  ISSUE: one cycle; at the clock edge register rsp_data=dev_out, rsp_id=grant,
//   rsp_err=(opcode==2'b11 && in2==0); if rsp_err then rsp_data=0 regardless of
//   dev_out. Set rsp_valid=1; -> RESP.
//  RESP: rsp_valid, rsp_data, rsp_id, rsp_err held stable until rsp_ready=1.
//   On handshake: rsp_valid=0, op_count+=1 (wraps), rr_ptr=(grant+1) mod NUM_REQ,
//   -> IDLE. No new request accepted in the handshake cycle.
//  Latency: accept at edge T -> rsp_valid high after edge T+1 (visible in the
//   cycle after ISSUE). Peak throughput one operation per 3 cycles.
//  A requester deasserting req_valid without handshake is not an error; nothing is
//   captured. Operand changes after acceptance do not affect the result.
//  Unused opcodes (00, 01) are passed through; result is whatever device returns.
//  rst asserted in any state aborts the in-flight operation: no response is
//   produced, all state returns to reset values on that edge.
// TESTING
//  T1 req0: in1=2,in2=3,op=10 -> req_ready[0] same cycle; rsp_data=6,rsp_id=0,
//     rsp_err=0 two edges later; op_count=1 after rsp handshake.
//  T2 req1: in1=6,in2=3,op=11 -> rsp_data=2, rsp_id=1, rsp_err=0.
//  T3 req0 and req1 both valid and held after reset -> serviced order 0,1,0,1;
//     req_ready never has two bits set.
//  T4 req0: in1=9,in2=0,op=11 -> rsp_err=1, rsp_data=0; next op 15*15 op=10
//     -> rsp_data=225, rsp_err=0.
//  T5 rsp_ready held 0 for 5 cycles with req1 valid -> rsp fields stable,
//     req_ready=0, busy=1; release -> one handshake, then req1 granted.
//  T6 rst pulsed in ISSUE, then in RESP -> rsp_valid=0, busy=0, op_count
//     unchanged by aborted ops; preload op_count to all-ones -> next rsp wraps to 0.

Source files
------------

// File: rtl/alu_req_arbiter.sv
// Round-robin front end that time-shares one combinational arithmetic device among
// several requesters and returns each registered result tagged with its requester ID.
module alu_req_arbiter #(
  parameter  int NUM_REQ = 2,
  parameter  int DATA_W  = 4,
  parameter  int CNT_W   = 16,
  localparam int IDW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*DATA_W-1:0] req_in1,
  input  logic [NUM_REQ*DATA_W-1:0] req_in2,
  input  logic [NUM_REQ*2-1:0]      req_opcode,
  output logic [DATA_W-1:0]         dev_in1,
  output logic [DATA_W-1:0]         dev_in2,
  output logic [1:0]                dev_opcode,
  input  logic [2*DATA_W-1:0]       dev_out,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [2*DATA_W-1:0]       rsp_data,
  output logic [IDW-1:0]            rsp_id,
  output logic                      rsp_err,
  output logic                      busy,
  output logic [CNT_W-1:0]          op_count
);

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, RESP = 2'd2} state_t;

  state_t              state_q, state_d;
  logic [IDW-1:0]      rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0]      grant_q, grant_d;
  logic [DATA_W-1:0]   in1_q, in1_d, in2_q, in2_d;
  logic [1:0]          opc_q, opc_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [2*DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic [IDW-1:0]      rsp_id_q, rsp_id_d;
  logic                rsp_err_q, rsp_err_d;
  logic [CNT_W-1:0]    op_count_q, op_count_d;

  logic [DATA_W-1:0]   in1_arr [NUM_REQ];
  logic [DATA_W-1:0]   in2_arr [NUM_REQ];
  logic [1:0]          opc_arr [NUM_REQ];

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign in1_arr[gi] = req_in1[gi*DATA_W +: DATA_W];
      assign in2_arr[gi] = req_in2[gi*DATA_W +: DATA_W];
      assign opc_arr[gi] = req_opcode[gi*2 +: 2];
    end
  endgenerate

  // Search starts at rr_ptr and wraps; one extra bit keeps the sum from overflowing.
  logic           any_valid;
  logic [IDW-1:0] pick;
  logic [IDW:0]   cand;

  always_comb begin
    any_valid = 1'b0;
    pick      = '0;
    cand      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, rr_ptr_q} + (IDW+1)'(k);
      if (cand >= (IDW+1)'(NUM_REQ)) cand = cand - (IDW+1)'(NUM_REQ);
      if (!any_valid && req_valid[cand[IDW-1:0]]) begin
        any_valid = 1'b1;
        pick      = cand[IDW-1:0];
      end
    end
  end

  logic [IDW:0] next_ptr;

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    grant_d     = grant_q;
    in1_d       = in1_q;
    in2_d       = in2_q;
    opc_d       = opc_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_id_d    = rsp_id_q;
    rsp_err_d   = rsp_err_q;
    op_count_d  = op_count_q;
    req_ready   = '0;
    next_ptr    = {1'b0, grant_q} + (IDW+1)'(1);
    if (next_ptr >= (IDW+1)'(NUM_REQ)) next_ptr = '0;
    case (state_q)
      IDLE: begin
        if (any_valid) begin
          req_ready[pick] = 1'b1;
          in1_d           = in1_arr[pick];
          in2_d           = in2_arr[pick];
          opc_d           = opc_arr[pick];
          grant_d         = pick;
          state_d         = ISSUE;
        end
      end
      ISSUE: begin
        // Divide by zero masks whatever the device produced.
        rsp_err_d   = (opc_q == 2'b11) && (in2_q == '0);
        rsp_data_d  = rsp_err_d ? '0 : dev_out;
        rsp_id_d    = grant_q;
        rsp_valid_d = 1'b1;
        state_d     = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          op_count_d  = op_count_q + CNT_W'(1);
          rr_ptr_d    = next_ptr[IDW-1:0];
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      grant_q     <= '0;
      in1_q       <= '0;
      in2_q       <= '0;
      opc_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_id_q    <= '0;
      rsp_err_q   <= 1'b0;
      op_count_q  <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      grant_q     <= grant_d;
      in1_q       <= in1_d;
      in2_q       <= in2_d;
      opc_q       <= opc_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_id_q    <= rsp_id_d;
      rsp_err_q   <= rsp_err_d;
      op_count_q  <= op_count_d;
    end
  end

  assign dev_in1    = in1_q;
  assign dev_in2    = in2_q;
  assign dev_opcode = opc_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_data   = rsp_data_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_err    = rsp_err_q;
  assign busy       = (state_q != IDLE);
  assign op_count   = op_count_q;

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Scoreboard bench for alu_req_arbiter: a transaction-level model predicts grants,
// timing and results; a separate monitor compares each presented response.
module tb_alu_req_arbiter;
  localparam int N   = 2;
  localparam int W   = 4;
  localparam int CW  = 4;
  localparam int IDW = 1;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid, req_ready;
  logic [N*W-1:0] req_in1, req_in2;
  logic [N*2-1:0] req_opcode;
  logic [W-1:0]   dev_in1, dev_in2;
  logic [1:0]     dev_opcode;
  logic [2*W-1:0] dev_out;
  logic           rsp_valid, rsp_ready, rsp_err, busy;
  logic [2*W-1:0] rsp_data;
  logic [IDW-1:0] rsp_id;
  logic [CW-1:0]  op_count;

  alu_req_arbiter #(.NUM_REQ(N), .DATA_W(W), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_in1(req_in1), .req_in2(req_in2), .req_opcode(req_opcode),
    .dev_in1(dev_in1), .dev_in2(dev_in2), .dev_opcode(dev_opcode), .dev_out(dev_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_id(rsp_id), .rsp_err(rsp_err), .busy(busy), .op_count(op_count)
  );

  always #5 clk = ~clk;

  // Stand-in device; divide by zero returns all ones so masking is observable.
  always_comb begin
    case (dev_opcode)
      2'b00:   dev_out = {4'b0, dev_in1} + {4'b0, dev_in2};
      2'b01:   dev_out = {4'b0, dev_in1} - {4'b0, dev_in2};
      2'b10:   dev_out = {4'b0, dev_in1} * {4'b0, dev_in2};
      default: dev_out = (dev_in2 == 4'd0) ? 8'hFF : {4'b0, dev_in1 / dev_in2};
    endcase
  end

  typedef struct packed {
    logic [7:0]     data;
    logic [IDW-1:0] id;
    logic           err;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_mis = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t ref_op(input int a, input int b, input int op, input int id);
    exp_t e;
    e.id  = IDW'(id);
    e.err = 1'b0;
    case (op)
      0:       e.data = 8'((a + b) % 256);
      1:       e.data = 8'((a - b + 256) % 256);
      2:       e.data = 8'(a * b);
      default: begin
        if (b == 0) begin
          e.err  = 1'b1;
          e.data = 8'd0;
        end else begin
          e.data = 8'(a / b);
        end
      end
    endcase
    return e;
  endfunction

  // Transaction model: one op in flight, round-robin from the slot after the last winner.
  bit         pending = 0;
  int         since = 0, rr = 0, cur_id = 0, count = 0;
  logic [3:0] cur_a = '0, cur_b = '0;
  logic [1:0] cur_op = '0;

  always @(negedge clk) begin
    logic [N-1:0] exp_ready;
    int           g;
    exp_t         e;
    if (rst) begin
      pending = 0; since = 0; rr = 0; count = 0;
      cur_a = '0; cur_b = '0; cur_op = '0;
      q.delete();
    end else begin
      exp_ready = '0;
      g = -1;
      if (!pending) begin
        for (int k = 0; k < N; k++) begin
          int j;
          j = (rr + k) % N;
          if (g < 0 && req_valid[j]) g = j;
        end
      end
      if (g >= 0) exp_ready[g] = 1'b1;
      chk("req_ready", 32'(req_ready), 32'(exp_ready));
      chk("busy", 32'(busy), 32'(pending));
      chk("rsp_valid", 32'(rsp_valid), 32'(pending && since >= 1));
      chk("op_count", 32'(op_count), 32'(count % 16));
      chk("dev_in", 32'({dev_in1, dev_in2, dev_opcode}), 32'({cur_a, cur_b, cur_op}));
      if (g >= 0) begin
        cur_a  = req_in1[g*W +: W];
        cur_b  = req_in2[g*W +: W];
        cur_op = req_opcode[g*2 +: 2];
        e = ref_op(int'(cur_a), int'(cur_b), int'(cur_op), g);
        q.push_back(e);
        pending = 1; since = 0; cur_id = g;
      end else if (pending) begin
        if (since >= 1 && rsp_ready) begin
          pending = 0;
          rr = (cur_id + 1) % N;
          count++;
        end else begin
          since++;
        end
      end
    end
  end

  // Monitor: compares presented responses against the queue head, pops on handshake.
  bit last_v = 0;
  always @(posedge clk) begin
    #1;
    if (rst) begin
      last_v = 0;
    end else begin
      if (last_v && rsp_ready && q.size() > 0) void'(q.pop_front());
      if (rsp_valid) begin
        if (q.size() == 0) begin
          n_vec++; n_mis++;
          $display("FAIL rsp_unexpected: got id %0d data %0h expected no response at %0t",
                   rsp_id, rsp_data, $time);
        end else begin
          chk("rsp_data", 32'(rsp_data), 32'(q[0].data));
          chk("rsp_id", 32'(rsp_id), 32'(q[0].id));
          chk("rsp_err", 32'(rsp_err), 32'(q[0].err));
        end
      end
      last_v = rsp_valid;
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic set_ops(input int id, input int a, input int b, input int op);
    req_in1[id*W +: W]  = 4'(a);
    req_in2[id*W +: W]  = 4'(b);
    req_opcode[id*2 +: 2] = 2'(op);
  endtask

  task automatic wait_accept(input int id);
    bit ok;
    ok = 0;
    for (int t = 0; t < 30; t++) begin
      @(negedge clk);
      if (req_ready[id]) begin
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      n_vec++; n_mis++;
      $display("FAIL accept_timeout: got no req_ready[%0d] expected grant within 30 cycles", id);
    end
    step();
  endtask

  // Operands are scrambled after acceptance to show they are no longer sampled.
  task automatic issue(input int id, input int a, input int b, input int op);
    set_ops(id, a, b, op);
    req_valid[id] = 1'b1;
    wait_accept(id);
    req_valid[id] = 1'b0;
    set_ops(id, int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), int'($urandom_range(0, 3)));
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    n_vec++; n_mis++;
    $display("FAIL watchdog: got no completion expected finish before 100000ns");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

  initial begin
    rst = 1'b1; req_valid = '0; req_in1 = '0; req_in2 = '0; req_opcode = '0; rsp_ready = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    @(negedge clk);
    chk("reset_rsp_data", 32'(rsp_data), 32'd0);
    chk("reset_rsp_id", 32'(rsp_id), 32'd0);
    chk("reset_rsp_err", 32'(rsp_err), 32'd0);
    step();

    issue(0, 2, 3, 2);                     // 2*3
    repeat (4) step();
    issue(1, 6, 3, 3);                     // 6/3
    repeat (4) step();

    pulse_reset();                         // both requesters held: 0,1,0,1
    set_ops(0, 3, 5, 2);
    set_ops(1, 14, 4, 3);
    req_valid = 2'b11;
    repeat (12) step();
    req_valid = '0;
    repeat (4) step();

    issue(0, 9, 0, 3);                     // divide by zero
    repeat (4) step();
    issue(0, 15, 15, 2);                   // 225
    repeat (4) step();

    rsp_ready = 1'b0;                      // response stall with req1 waiting
    issue(0, 7, 7, 2);
    set_ops(1, 12, 5, 3);
    req_valid[1] = 1'b1;
    repeat (5) step();
    rsp_ready = 1'b1;
    wait_accept(1);
    req_valid[1] = 1'b0;
    repeat (4) step();

    issue(1, 4, 4, 2);                     // reset during ISSUE
    pulse_reset();
    repeat (2) step();
    rsp_ready = 1'b0;                      // reset during RESP
    issue(0, 5, 2, 0);
    repeat (2) step();
    pulse_reset();
    rsp_ready = 1'b1;
    repeat (2) step();

    for (int i = 0; i < 17; i++) begin     // counter wraps past all-ones
      issue(int'($urandom_range(0, N-1)), int'($urandom_range(0, 15)),
            int'($urandom_range(0, 15)), int'($urandom_range(0, 3)));
    end
    repeat (4) step();

    for (int i = 0; i < 300; i++) begin
      req_valid  = N'($urandom);
      req_in1    = (N*W)'($urandom);
      req_in2    = (N*W)'($urandom);
      req_opcode = (N*2)'($urandom);
      rsp_ready  = ($urandom_range(0, 3) != 0);
      rst        = ($urandom_range(0, 79) == 0);
      step();
    end
    rst = 1'b0; req_valid = '0; rsp_ready = 1'b1;
    repeat (6) step();
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
